// File: rtl/traffic_pkg.sv
// Shared types for the traffic controller: FSM states and the lamp colour
// each state drives onto the intersection.
package traffic_pkg;

  typedef enum logic [2:0] {
    GREEN,
    AMBER,
    CLEAR,
    PREEMPT_CLR,
    PREEMPT
  } state_t;

  typedef enum logic [1:0] {
    LAMP_DARK,
    LAMP_GREEN,
    LAMP_AMBER,
    LAMP_RED
  } lamp_t;

  function automatic lamp_t lamp_for(state_t s);
    case (s)
      GREEN, PREEMPT:     return LAMP_GREEN;
      AMBER:              return LAMP_AMBER;
      CLEAR, PREEMPT_CLR: return LAMP_RED;
      default:            return LAMP_DARK;
    endcase
  endfunction

endpackage

// File: rtl/traffic_ctrl_gen_if.sv
// Sensor/emergency inputs and lamp/status outputs of the intersection
// controller; master is the environment side, slave is the controller.
interface traffic_ctrl_gen_if #(
  parameter int N_PHASES       = 4,
  parameter int SENS_PER_PHASE = 2,
  parameter int CNT_W          = 8
);
  localparam int PW = $clog2(N_PHASES);

  logic [N_PHASES*SENS_PER_PHASE-1:0] sensors;
  logic                               emerg_req;
  logic [PW-1:0]                      emerg_phase;
  logic [N_PHASES-1:0]                green;
  logic [N_PHASES-1:0]                amber;
  logic                               all_red;
  logic [PW-1:0]                      cur_phase;
  logic [CNT_W-1:0]                   busy_cnt;

  modport master (
    output sensors, emerg_req, emerg_phase,
    input  green, amber, all_red, cur_phase, busy_cnt
  );

  modport slave (
    input  sensors, emerg_req, emerg_phase,
    output green, amber, all_red, cur_phase, busy_cnt
  );

endinterface

// File: rtl/rr_phase_sel.sv
// Round-robin scan for the next phase to serve, starting just after cur_phase.
// The current phase is the last candidate so a lone request on it is not lost.
module rr_phase_sel #(
  parameter  int N_PHASES = 4,
  localparam int PW       = $clog2(N_PHASES)
) (
  input  logic [N_PHASES-1:0] req,
  input  logic [PW-1:0]       cur_phase,
  output logic [PW-1:0]       next_phase,
  output logic                any_other
);

  logic [PW-1:0] idx;

  // Walk from farthest to nearest so the closest requester is written last.
  always_comb begin
    next_phase = PW'((int'(cur_phase) + 1) % N_PHASES);
    any_other  = 1'b0;
    idx        = '0;
    for (int i = N_PHASES; i >= 1; i--) begin
      idx = PW'((int'(cur_phase) + i) % N_PHASES);
      if (req[idx]) begin
        next_phase = idx;
        if (i != N_PHASES) any_other = 1'b1;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_gen.sv
// Sensor-driven N-phase intersection controller with amber, all-red clearance
// and emergency preemption; all lamp outputs come straight from registers.
module traffic_ctrl_gen
  import traffic_pkg::*;
#(
  parameter int N_PHASES       = 4,
  parameter int SENS_PER_PHASE = 2,
  parameter int CNT_W          = 8,
  parameter int GREEN_UNIT     = 30,
  parameter int MIN_GREEN      = 10,
  parameter int AMBER_T        = 5,
  parameter int CLEAR_T        = 2
) (
  input  logic             clk,
  input  logic             rst,
  traffic_ctrl_gen_if.slave bus
);

  localparam int PW = $clog2(N_PHASES);
  localparam logic [CNT_W-1:0] MIN_LOAD   = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] AMBER_LOAD = CNT_W'(AMBER_T - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_T - 1);

  state_t              state, state_n;
  logic [PW-1:0]       cur_phase, phase_n;
  logic [CNT_W-1:0]    busy_cnt, cnt_n;
  logic                pend, pend_n;
  logic [PW-1:0]       target, target_n;
  logic [N_PHASES-1:0] green_q, green_n;
  logic [N_PHASES-1:0] amber_q, amber_n;
  logic                all_red_q, all_red_n;

  logic [N_PHASES-1:0] req_vec;
  int                  pc [N_PHASES];
  logic [PW-1:0]       scan_phase;
  logic                any_other;
  logic                phase_ok;
  logic                ereq;

  // Product saturates at the counter's full scale instead of wrapping.
  function automatic logic [CNT_W-1:0] green_load(input int k);
    int len;
    if (k == 0) begin
      len = MIN_GREEN;
    end else begin
      len = GREEN_UNIT * k;
      if (len > (1 << CNT_W) - 1) len = (1 << CNT_W) - 1;
    end
    return CNT_W'(len - 1);
  endfunction

  for (genvar p = 0; p < N_PHASES; p++) begin : g_phase
    assign req_vec[p] = |bus.sensors[p*SENS_PER_PHASE +: SENS_PER_PHASE];
    assign pc[p]      = $countones(bus.sensors[p*SENS_PER_PHASE +: SENS_PER_PHASE]);
  end

  rr_phase_sel #(
    .N_PHASES (N_PHASES)
  ) u_sel (
    .req        (req_vec),
    .cur_phase  (cur_phase),
    .next_phase (scan_phase),
    .any_other  (any_other)
  );

  always_comb begin
    phase_ok = 1'b0;
    for (int p = 0; p < N_PHASES; p++) begin
      if (bus.emerg_phase == PW'(p)) phase_ok = 1'b1;
    end
  end

  assign ereq = bus.emerg_req & phase_ok;

  // Preempt requests are tested before interval expiry so they win a tie.
  always_comb begin
    state_n  = state;
    phase_n  = cur_phase;
    cnt_n    = busy_cnt - 1'b1;
    pend_n   = pend;
    target_n = target;
    case (state)
      GREEN: begin
        if (ereq && bus.emerg_phase != cur_phase) begin
          state_n  = AMBER;
          cnt_n    = AMBER_LOAD;
          pend_n   = 1'b1;
          target_n = bus.emerg_phase;
        end else if (ereq) begin
          state_n = PREEMPT;
          cnt_n   = '0;
        end else if (busy_cnt == '0) begin
          if (any_other) begin
            state_n = AMBER;
            cnt_n   = AMBER_LOAD;
          end else begin
            cnt_n = MIN_LOAD;
          end
        end
      end
      AMBER: begin
        if (ereq && !pend) begin
          pend_n   = 1'b1;
          target_n = bus.emerg_phase;
        end
        if (busy_cnt == '0) begin
          state_n = pend_n ? PREEMPT_CLR : CLEAR;
          cnt_n   = CLEAR_LOAD;
        end
      end
      CLEAR: begin
        if (ereq) begin
          state_n  = PREEMPT_CLR;
          cnt_n    = CLEAR_LOAD;
          pend_n   = 1'b1;
          target_n = bus.emerg_phase;
        end else if (busy_cnt == '0) begin
          state_n = GREEN;
          phase_n = scan_phase;
          cnt_n   = green_load(pc[scan_phase]);
        end
      end
      PREEMPT_CLR: begin
        if (busy_cnt == '0) begin
          state_n = PREEMPT;
          phase_n = target;
          cnt_n   = '0;
          pend_n  = 1'b0;
        end
      end
      PREEMPT: begin
        cnt_n = '0;
        if (!ereq) begin
          state_n = AMBER;
          cnt_n   = AMBER_LOAD;
        end
      end
      default: begin
        state_n = GREEN;
        cnt_n   = MIN_LOAD;
      end
    endcase
  end

  always_comb begin
    green_n   = '0;
    amber_n   = '0;
    all_red_n = 1'b0;
    case (lamp_for(state_n))
      LAMP_GREEN: green_n[phase_n] = 1'b1;
      LAMP_AMBER: amber_n[phase_n] = 1'b1;
      LAMP_RED:   all_red_n        = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= GREEN;
      cur_phase <= '0;
      busy_cnt  <= MIN_LOAD;
      pend      <= 1'b0;
      target    <= '0;
      green_q   <= N_PHASES'(1);
      amber_q   <= '0;
      all_red_q <= 1'b0;
    end else begin
      state     <= state_n;
      cur_phase <= phase_n;
      busy_cnt  <= cnt_n;
      pend      <= pend_n;
      target    <= target_n;
      green_q   <= green_n;
      amber_q   <= amber_n;
      all_red_q <= all_red_n;
    end
  end

  assign bus.green     = green_q;
  assign bus.amber     = amber_q;
  assign bus.all_red   = all_red_q;
  assign bus.cur_phase = cur_phase;
  assign bus.busy_cnt  = busy_cnt;

endmodule
